rename_unit: RTL and testbench

Register-rename stage (RR). Consumes the `rr_uops` group registered by the ID→RR pipeline register and maps architectural registers to physical registers through a speculative RAT and a circular free list. Renamed micro-ops go to dispatch through an output register. A committed RAT and a committed free-list head, both updated at commit, give single-cycle recovery on `clear`.

---
 rtl/rename_unit.sv | 151 +++++++++++++++
 tb/tb_rename_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register-rename stage: maps architectural to physical registers through a
// speculative RAT and a circular free list. A committed RAT and committed
// free-list head give single-cycle recovery on clear.

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif

package rename_pkg;
    // Physical tag width carried in the micro-op; covers up to 64 physical regs.
    localparam int unsigned TAG_W = 6;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             rd_valid;
        logic [TAG_W-1:0] prs1;
        logic [TAG_W-1:0] prs2;
        logic [TAG_W-1:0] prd;
        logic [TAG_W-1:0] old_prd;
    } micro_op_t;
endpackage

module rename_unit
    import rename_pkg::*;
#(
    parameter int unsigned RENAME_WIDTH = `RENAME_WIDTH,
    parameter int unsigned COMMIT_WIDTH = 4,
    parameter int unsigned ARCH_REGS    = 32,
    parameter int unsigned PHYS_REGS    = 64,
    localparam int unsigned PRW         = $clog2(PHYS_REGS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                stall_in,
    input  micro_op_t [RENAME_WIDTH-1:0]        rr_uops,
    output logic                                stall_out,
    output micro_op_t [RENAME_WIDTH-1:0]        dp_uops,
    input  logic [COMMIT_WIDTH-1:0]             commit_valid,
    input  logic [COMMIT_WIDTH-1:0][4:0]        commit_rd,
    input  logic [COMMIT_WIDTH-1:0][PRW-1:0]    commit_prd,
    input  logic [COMMIT_WIDTH-1:0][PRW-1:0]    commit_old_prd
);

    localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned FLW      = $clog2(FL_DEPTH);
    localparam int unsigned PTRW     = FLW + 1;
    localparam int unsigned ARW      = $clog2(ARCH_REGS);

    logic [ARCH_REGS-1:0][PRW-1:0]  spec_rat;
    logic [ARCH_REGS-1:0][PRW-1:0]  rat_work;
    logic [ARCH_REGS-1:0][PRW-1:0]  commit_rat;
    logic [ARCH_REGS-1:0][PRW-1:0]  commit_rat_next;
    logic [FL_DEPTH-1:0][PRW-1:0]   free_list;
    logic [PTRW-1:0]                head;
    logic [PTRW-1:0]                tail;
    logic [PTRW-1:0]                committed_head;
    logic [PTRW-1:0]                count;
    logic [PTRW-1:0]                n_alloc;
    logic [PTRW-1:0]                n_commit;
    logic [COMMIT_WIDTH-1:0][FLW-1:0] push_slot;
    micro_op_t [RENAME_WIDTH-1:0]   renamed;

    // Rename the incoming group: lanes see earlier lanes' destinations through rat_work.
    always_comb begin
        rat_work = spec_rat;
        renamed  = rr_uops;
        n_alloc  = '0;
        for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
            renamed[k].prs1    = (rr_uops[k].rs1 == '0) ? '0 : TAG_W'(rat_work[ARW'(rr_uops[k].rs1)]);
            renamed[k].prs2    = (rr_uops[k].rs2 == '0) ? '0 : TAG_W'(rat_work[ARW'(rr_uops[k].rs2)]);
            renamed[k].old_prd = (rr_uops[k].rd == '0)  ? '0 : TAG_W'(rat_work[ARW'(rr_uops[k].rd)]);
            renamed[k].prd     = '0;
            if (rr_uops[k].valid && rr_uops[k].rd_valid && (rr_uops[k].rd != '0)) begin
                renamed[k].prd = TAG_W'(free_list[FLW'(head + n_alloc)]);
                rat_work[ARW'(rr_uops[k].rd)] = free_list[FLW'(head + n_alloc)];
                n_alloc = n_alloc + 1'b1;
            end
        end
    end

    // Apply this cycle's commits to the committed RAT and compute free-list push slots.
    always_comb begin
        commit_rat_next = commit_rat;
        n_commit        = '0;
        push_slot       = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            push_slot[k] = FLW'(tail + n_commit);
            if (commit_valid[k]) begin
                if (commit_rd[k] != '0) begin
                    commit_rat_next[ARW'(commit_rd[k])] = commit_prd[k];
                end
                n_commit = n_commit + 1'b1;
            end
        end
    end

    // Stall compares against the registered occupancy only.
    always_comb begin
        count     = tail - head;
        stall_out = stall_in | (n_alloc > count);
    end

    // Committed state and free-list storage advance every cycle, stalled or not.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                commit_rat[i] <= PRW'(i);
            end
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                free_list[i] <= PRW'(ARCH_REGS + i);
            end
            tail           <= PTRW'(FL_DEPTH);
            committed_head <= '0;
        end else begin
            commit_rat <= commit_rat_next;
            for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
                if (commit_valid[k]) begin
                    free_list[push_slot[k]] <= commit_old_prd[k];
                end
            end
            tail           <= tail + n_commit;
            committed_head <= committed_head + n_commit;
        end
    end

    // Speculative state and output register: clear restores, stalls hold or bubble.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                spec_rat[i] <= PRW'(i);
            end
            head    <= '0;
            dp_uops <= '0;
        end else if (clear) begin
            spec_rat <= commit_rat_next;
            head     <= committed_head + n_commit;
            dp_uops  <= '0;
        end else if (!stall_out) begin
            spec_rat <= rat_work;
            head     <= head + n_alloc;
            dp_uops  <= renamed;
        end else if (!stall_in) begin
            dp_uops <= '0;
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: a queue-based free-list/RAT model feeds a
// scoreboard of expected dp_uops, plus directed checks of the documented scenarios.

module tb_rename_unit;
    import rename_pkg::*;

    localparam int unsigned RW  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned PRW = 6;

    typedef micro_op_t [RW-1:0] grp_t;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   clear;
    logic                   stall_in;
    grp_t                   rr_uops;
    logic                   stall_out;
    grp_t                   dp_uops;
    logic [CW-1:0]          commit_valid;
    logic [CW-1:0][4:0]     commit_rd;
    logic [CW-1:0][PRW-1:0] commit_prd;
    logic [CW-1:0][PRW-1:0] commit_old_prd;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference state: free registers and not-yet-committed allocations as queues.
    logic [31:0][PRW-1:0] m_rat;
    logic [31:0][PRW-1:0] m_crat;
    logic [31:0][PRW-1:0] id_rat;
    logic [PRW-1:0]       m_fl [$];
    logic [PRW-1:0]       m_unc [$];
    grp_t                 m_dp;
    grp_t                 sb [$];
    logic                 m_stall;

    rename_unit #(
        .RENAME_WIDTH (RW),
        .COMMIT_WIDTH (CW),
        .ARCH_REGS    (32),
        .PHYS_REGS    (64)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .stall_in       (stall_in),
        .rr_uops        (rr_uops),
        .stall_out      (stall_out),
        .dp_uops        (dp_uops),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_prd     (commit_prd),
        .commit_old_prd (commit_old_prd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic micro_op_t uop(input logic v, input logic rdv, input int unsigned rd,
                                      input int unsigned rs1, input int unsigned rs2);
        micro_op_t u;
        u          = '0;
        u.valid    = v;
        u.rd_valid = rdv;
        u.rd       = 5'(rd);
        u.rs1      = 5'(rs1);
        u.rs2      = 5'(rs2);
        return u;
    endfunction

    function automatic logic is_alloc(input micro_op_t u);
        return u.valid && u.rd_valid && (u.rd != 5'd0);
    endfunction

    // Four allocating uops with destinations first_rd.. (wrapping within x1..x31).
    function automatic grp_t alloc_group(input int unsigned first_rd);
        grp_t g;
        for (int k = 0; k < RW; k++) begin
            g[k] = uop(1'b1, 1'b1, ((first_rd - 1 + k) % 31) + 1,
                       (first_rd + k + 7) % 32, (k * 3) % 32);
        end
        return g;
    endfunction

    task automatic set_commit(input int unsigned rd0, input int unsigned prd0, input int unsigned old0);
        for (int k = 0; k < CW; k++) begin
            commit_valid[k]   = 1'b1;
            commit_rd[k]      = 5'(rd0 + k);
            commit_prd[k]     = PRW'(prd0 + k);
            commit_old_prd[k] = PRW'(old0 + k);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = PRW'(i);
        m_crat = m_rat;
        m_fl.delete();
        m_unc.delete();
        for (int i = 32; i < 64; i++) m_fl.push_back(PRW'(i));
        m_dp = '0;
    endtask

    task automatic model_commit();
        for (int k = 0; k < CW; k++) begin
            if (commit_valid[k]) begin
                if (commit_rd[k] != 5'd0) m_crat[commit_rd[k]] = commit_prd[k];
                if (m_unc.size() > 0) void'(m_unc.pop_front());
                m_fl.push_back(commit_old_prd[k]);
            end
        end
    endtask

    // One clock: predict at negedge, let the DUT clock, then pop and compare at posedge+1.
    task automatic step();
        grp_t           g;
        grp_t           exp_dp;
        int             na;
        logic [PRW-1:0] p;
        @(negedge clock);
        na = 0;
        for (int k = 0; k < RW; k++) if (is_alloc(rr_uops[k])) na++;
        if (!reset) begin
            model_reset();
        end else begin
            m_stall = stall_in || (na > m_fl.size());
            check("stall_out", 256'(stall_out), 256'(m_stall));
            if (clear) begin
                model_commit();
                for (int i = m_unc.size() - 1; i >= 0; i--) m_fl.push_front(m_unc[i]);
                m_unc.delete();
                m_rat = m_crat;
                m_dp  = '0;
            end else if (!m_stall) begin
                g = rr_uops;
                for (int k = 0; k < RW; k++) begin
                    g[k].prs1    = (g[k].rs1 == 5'd0) ? '0 : m_rat[g[k].rs1];
                    g[k].prs2    = (g[k].rs2 == 5'd0) ? '0 : m_rat[g[k].rs2];
                    g[k].old_prd = (g[k].rd == 5'd0)  ? '0 : m_rat[g[k].rd];
                    g[k].prd     = '0;
                    if (is_alloc(g[k])) begin
                        p = m_fl.pop_front();
                        m_unc.push_back(p);
                        g[k].prd = p;
                        m_rat[g[k].rd] = p;
                    end
                end
                m_dp = g;
                model_commit();
            end else begin
                if (!stall_in) m_dp = '0;
                model_commit();
            end
        end
        sb.push_back(m_dp);
        @(posedge clock);
        #1;
        exp_dp = sb.pop_front();
        check("dp_uops", 256'(dp_uops), 256'(exp_dp));
        check("count", 256'(dut.count), 256'(m_fl.size()));
        check("spec_rat", 256'(dut.spec_rat), 256'(m_rat));
        commit_valid = '0;
        clear        = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        rr_uops = '0;
        step();
        reset   = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) id_rat[i] = PRW'(i);
        reset          = 1'b0;
        clear          = 1'b0;
        stall_in       = 1'b0;
        rr_uops        = '0;
        commit_valid   = '0;
        commit_rd      = '0;
        commit_prd     = '0;
        commit_old_prd = '0;

        // Reset held for two cycles
        step();
        step();
        reset = 1'b1;
        check("rst_dp", 256'(dp_uops), 256'(0));
        check("rst_stall", 256'(stall_out), 256'(0));
        check("rst_count", 256'(dut.count), 256'(32));
        check("rst_rat", 256'(dut.spec_rat), 256'(id_rat));

        // Intra-group dependency
        rr_uops[0] = uop(1'b1, 1'b1, 1, 2, 3);
        rr_uops[1] = uop(1'b1, 1'b1, 4, 1, 1);
        rr_uops[2] = uop(1'b1, 1'b1, 1, 4, 0);
        rr_uops[3] = uop(1'b1, 1'b0, 0, 0, 0);
        step();
        check("ig_prd0", 256'(dp_uops[0].prd), 256'(32));
        check("ig_prd1", 256'(dp_uops[1].prd), 256'(33));
        check("ig_prd2", 256'(dp_uops[2].prd), 256'(34));
        check("ig_prd3", 256'(dp_uops[3].prd), 256'(0));
        check("ig_l1_prs1", 256'(dp_uops[1].prs1), 256'(32));
        check("ig_l1_prs2", 256'(dp_uops[1].prs2), 256'(32));
        check("ig_l2_prs1", 256'(dp_uops[2].prs1), 256'(33));
        check("ig_l2_prs2", 256'(dp_uops[2].prs2), 256'(0));
        check("ig_l2_old", 256'(dp_uops[2].old_prd), 256'(32));
        rr_uops    = '0;
        rr_uops[0] = uop(1'b1, 1'b1, 5, 1, 1);
        step();
        check("ig_next_prs1", 256'(dp_uops[0].prs1), 256'(34));

        // Exhaustion and refill from commit
        do_reset();
        for (int g = 0; g < 8; g++) begin
            rr_uops = alloc_group(g * 4 + 1);
            step();
        end
        check("exh_count", 256'(dut.count), 256'(0));
        rr_uops = alloc_group(33);
        step();
        check("exh_bubble", 256'(dp_uops), 256'(0));
        check("exh_stall", 256'(stall_out), 256'(1));
        set_commit(1, 32, 1);
        step();
        check("exh_stall_drop", 256'(stall_out), 256'(0));
        step();
        for (int k = 0; k < RW; k++) check("exh_refill_prd", 256'(dp_uops[k].prd), 256'(k + 1));

        // Downstream stall holds output, pointers and RAT
        do_reset();
        rr_uops = alloc_group(1);
        step();
        rr_uops  = alloc_group(5);
        stall_in = 1'b1;
        repeat (3) step();
        check("stl_hold", 256'(dp_uops[0].prd), 256'(32));
        check("stl_count", 256'(dut.count), 256'(28));
        stall_in = 1'b0;
        step();
        check("stl_release", 256'(dp_uops[0].prd), 256'(36));

        // Flush after committing only the first of three groups
        do_reset();
        for (int g = 0; g < 3; g++) begin
            rr_uops = alloc_group(g * 4 + 1);
            step();
        end
        rr_uops = '0;
        set_commit(1, 32, 1);
        step();
        clear = 1'b1;
        step();
        check("fl_head", 256'(dut.head), 256'(4));
        check("fl_x1", 256'(dut.spec_rat[1]), 256'(32));
        check("fl_x5", 256'(dut.spec_rat[5]), 256'(5));
        rr_uops = alloc_group(1);
        step();
        for (int k = 0; k < RW; k++) check("fl_realloc_prd", 256'(dp_uops[k].prd), 256'(36 + k));

        // Clear and commit in the same cycle
        do_reset();
        for (int g = 0; g < 2; g++) begin
            rr_uops = alloc_group(g * 4 + 1);
            step();
        end
        rr_uops = '0;
        set_commit(1, 32, 1);
        clear = 1'b1;
        step();
        check("cc_head", 256'(dut.head), 256'(4));
        check("cc_x1", 256'(dut.spec_rat[1]), 256'(32));
        check("cc_count", 256'(dut.count), 256'(32));
        rr_uops = alloc_group(9);
        step();
        check("cc_prd0", 256'(dp_uops[0].prd), 256'(36));

        // Reset asserted mid-stream
        rr_uops = alloc_group(13);
        step();
        reset = 1'b0;
        step();
        check("mid_dp", 256'(dp_uops), 256'(0));
        check("mid_count", 256'(dut.count), 256'(32));
        check("mid_head", 256'(dut.head), 256'(0));
        check("mid_rat", 256'(dut.spec_rat), 256'(id_rat));
        reset   = 1'b1;
        rr_uops = alloc_group(1);
        step();
        check("mid_after_prd0", 256'(dp_uops[0].prd), 256'(32));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
